seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for operands wider than a single-cycle compare should handle.
- Latches two WIDTH-bit operands on a start handshake, then compares them CHUNK bits per cycle, MSB chunk first.
- Reports one-hot greater/equal/less with a one-cycle done pulse.
- Supports an unsigned or two's-complement mode per operation; sits beside datapath blocks that need ordered compares without a wide combinational chain.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; chunk count and index range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- busy  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- done  out  1  one-cycle pulse; gt/eq/lt are valid in the same cycle.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy, done, gt, eq, lt all 0; internal registers cleared.
- States: IDLE, CMP, DONE.
- IDLE -> CMP: on start=1 at a clock edge.
  - Register a, b and is_signed.
  - When is_signed=1, invert the MSB of both captured operands, so signed order maps to unsigned order.
  - Set idx=NCHUNK-1 and busy=1.
- CMP: each cycle compare chunk idx of A against chunk idx of B.
  - While the chunks are equal and idx>0, decrement idx.
  - At idx==0 with no difference: result = eq.
  - On the first differing chunk, record gt or lt and freeze it. Later chunks are not evaluated into the result.
  - Termination depends on the optional feature (see below).
- DONE: held exactly one cycle.
  - done=1 and busy=1.
  - gt/eq/lt updated to the new result; exactly one of them is high.
  - Next state is always IDLE.
- Latency without the early-exit feature: fixed. done is asserted NCHUNK+1 cycles after the accepting edge (CMP lasts NCHUNK cycles).
- Result hold: gt/eq/lt keep their value until the next DONE. They are not cleared on a new start. Before the first completed compare they are all 0.
- start while not in IDLE (CMP or DONE): ignored, with no queuing. The earliest re-accept is the cycle after DONE.
- Input changes on a, b or is_signed after acceptance have no effect on the operation in flight.
- rst_n asserted mid-operation: immediate abort to reset values, and no done pulse.
- CHUNK==WIDTH: a single CMP cycle; done arrives 2 cycles after acceptance.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: CMP moves to DONE on the edge after the first differing chunk is evaluated.
  - Latency = k+1 cycles, where k is the number of chunks evaluated (1..NCHUNK).
  - The equal case still takes NCHUNK+1 cycles.
- Undefined: fixed latency of NCHUNK+1 for all operands; the result is frozen at the first difference.
- gt/eq/lt values are identical in both builds; only done/busy timing differs.

Decomposition:
- Shared package/include cmp_pkg:
  - State encoding constants ST_IDLE, ST_CMP, ST_DONE (2-bit).
  - Result encoding constants RES_GT, RES_EQ, RES_LT (one-hot, 3-bit).
- One natural sub-module, cmp_chunk: a combinational CHUNK-bit unsigned comparator producing chunk_gt and chunk_eq, instantiated once and fed by an idx-selected slice.
- FSM, operand registers, idx counter and result registers live in the top module.

Test Plan:
- WIDTH=16, CHUNK=4, unsigned, a=16'h1234, b=16'h1234 -> done 5 cycles after accept; eq=1, gt=lt=0; busy high for 5 cycles.
- a=16'h8000, b=16'h7FFF: with is_signed=0 -> gt=1; repeated with is_signed=1 -> lt=1.
- Signed equal and wrap: a=16'hFFFF, b=16'hFFFF, signed -> eq=1; a=16'h0001, b=16'hFFFF, signed -> gt=1.
- a=16'hA000, b=16'h5000, unsigned -> gt=1.
  - With SEQ_CMP_EARLY_EXIT_EN: done 2 cycles after accept.
  - Without it: done 5 cycles after accept.
- Accept a=16'h0010, b=16'h0020.
  - Pulse start again and change a to 16'hFFFF during CMP: the second start is ignored and the result is lt=1.
  - A start in the cycle after DONE is accepted.
- Drop rst_n low for 1 cycle during the second CMP cycle -> busy/done/gt/eq/lt go to 0 immediately with no done pulse; a subsequent compare of a=16'h0003, b=16'h0002 returns gt=1 with normal latency.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator:
// FSM state constants and one-hot result constants {gt, eq, lt}.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned comparator used for one slice per cycle.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             chunk_gt,
  output logic             chunk_eq
);

  assign chunk_gt = (a > b);
  assign chunk_eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: captures A/B on start, compares one
// CHUNK-bit slice per cycle from the MSB end, and reports one-hot gt/eq/lt
// with a single-cycle done pulse.
//
// Handshake: start is sampled only while idle; an accepted start launches one
// operation, busy stays high until the done cycle inclusive, and any start
// seen while busy is dropped (no queuing).
//
// Optional build macro SEQ_CMP_EARLY_EXIT_EN: when defined, the compare ends
// on the first differing chunk instead of always walking all NCHUNK chunks.
// Results are identical in both builds; only done/busy timing differs.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx_q;
  logic             found_q;    // a differing chunk has already been seen
  logic [2:0]       res_q;      // frozen result of the first difference
  logic [2:0]       res_out_q;  // result presented on gt/eq/lt

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_gt;
  logic             chunk_eq;
  logic             cmp_last;
  logic [2:0]       final_res;

  // Select the slice addressed by idx from both captured operands.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .a        (a_chunk),
    .b        (b_chunk),
    .chunk_gt (chunk_gt),
    .chunk_eq (chunk_eq)
  );

  // Decide whether this CMP cycle is the last one and what the result is.
  always_comb begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
    cmp_last = (idx_q == '0) || (!found_q && !chunk_eq);
`else
    cmp_last = (idx_q == '0);
`endif
    if (found_q)       final_res = res_q;
    else if (!chunk_eq) final_res = chunk_gt ? RES_GT : RES_LT;
    else               final_res = RES_EQ;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CMP;
      ST_CMP:  if (cmp_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Operand capture, chunk index walk, and result freeze/publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      res_q     <= '0;
      res_out_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        a_q     <= is_signed ? (a ^ MSB_MASK) : a;
        b_q     <= is_signed ? (b ^ MSB_MASK) : b;
        idx_q   <= IDX_W'(NCHUNK - 1);
        found_q <= 1'b0;
        res_q   <= '0;
      end else if (state_q == ST_CMP) begin
        if (!found_q && !chunk_eq) begin
          found_q <= 1'b1;
          res_q   <= chunk_gt ? RES_GT : RES_LT;
        end
        if (idx_q != '0) idx_q <= idx_q - IDX_W'(1);
        if (cmp_last) res_out_q <= final_res;
      end
    end
  end

  assign gt = res_out_q[2];
  assign eq = res_out_q[1];
  assign lt = res_out_q[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic        gt;
  logic        eq;
  logic        lt;

  int checks;
  int failures;
  int cyc;
  int busy_cyc;
  int done_seen;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected latency given k chunks needed to find the answer.
  function automatic int lat(input int k);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    return k + 1;
`else
    return 5;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one compare and wait (bounded) for done; ends at the done-cycle negedge.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        output int n_cyc, output int n_busy);
    @(negedge clk);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_cyc = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cyc++;
      if (busy) n_busy++;
      if (done) break;
    end
  endtask

  task automatic chk_res(input string tag, input logic [2:0] exp_gel);
    chk({tag, "_gel"}, {29'd0, gt, eq, lt}, {29'd0, exp_gel});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;

    // Reset state.
    #1;
    chk("reset_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);

    // Unsigned equal: fixed latency, busy through done.
    run_op(16'h1234, 16'h1234, 1'b0, cyc, busy_cyc);
    chk("eq_lat", cyc, 5);
    chk("eq_busy", busy_cyc, 5);
    chk_res("eq", 3'b010);
    @(negedge clk);
    chk("done_pulse_one", {31'd0, done}, 32'd0);
    chk("hold_after_done", {29'd0, gt, eq, lt}, 32'b010);

    // 8000 vs 7FFF unsigned then signed.
    run_op(16'h8000, 16'h7FFF, 1'b0, cyc, busy_cyc);
    chk("u8000_lat", cyc, lat(1));
    chk_res("u8000", 3'b100);
    run_op(16'h8000, 16'h7FFF, 1'b1, cyc, busy_cyc);
    chk("s8000_lat", cyc, lat(1));
    chk_res("s8000", 3'b001);

    // Signed equal and wrap.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, cyc, busy_cyc);
    chk("sffff_lat", cyc, 5);
    chk_res("sffff", 3'b010);
    run_op(16'h0001, 16'hFFFF, 1'b1, cyc, busy_cyc);
    chk("s0001_lat", cyc, lat(1));
    chk_res("s0001", 3'b100);

    // Early-exit sensitive case.
    run_op(16'hA000, 16'h5000, 1'b0, cyc, busy_cyc);
    chk("a000_lat", cyc, lat(1));
    chk("a000_busy", busy_cyc, lat(1));
    chk_res("a000", 3'b100);

    // Results are not cleared by a new start.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("hold_on_start", {29'd0, gt, eq, lt}, 32'b100);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    // Second start with a changed during CMP must be ignored.
    @(negedge clk);
    a = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("ign_done_seen", done_seen, 1);
    chk("ign_lat", cyc, lat(3));
    chk_res("ign", 3'b001);
    // Start raised during DONE is ignored, then accepted in the idle cycle.
    a = 16'h0003; b = 16'h0002; start = 1'b1;
    @(negedge clk);
    chk("done_start_ignored", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("reaccept_busy", {31'd0, busy}, 32'd1);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        break;
      end
    end
    chk("reaccept_done", done_seen, 1);
    chk_res("reaccept", 3'b100);

    // Asynchronous reset during the second CMP cycle.
    @(negedge clk);
    a = 16'h1234; b = 16'h0000; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 0);

    // Normal compare after the abort.
    run_op(16'h0003, 16'h0002, 1'b0, cyc, busy_cyc);
    chk("post_abort_lat", cyc, 5);
    chk_res("post_abort", 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
